// File: rtl/period_meter.sv
// Period and high-time meter for a slow external square wave.
// Results are averaged over 2^AVG_LOG2 periods; a dead input raises timeout.
module period_meter #(
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 0,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic             clk_100m,
  input  logic             rstn,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_valid,
  output logic             timeout,
  output logic             no_signal
);

  localparam int SW = CNT_W + AVG_LOG2;
  localparam int IW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IW-1:0] LAST = IW'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic {
    S_WAIT,
    S_MEAS
  } state_t;

  state_t state, state_nx;

  logic sync1, sig_s, sig_d, rise;
  logic [CNT_W-1:0] per_acc, hi_acc;
  logic [SW-1:0] per_sum, hi_sum;
  logic [SW-1:0] per_tot, hi_tot;
  logic [IW-1:0] avg_idx;
  logic arm, tick, close, expire, fire;

  assign rise    = sig_s & ~sig_d;
  assign per_tot = per_sum + SW'(per_acc);
  assign hi_tot  = hi_sum + SW'(hi_acc);
  assign fire    = close && (avg_idx == LAST);

  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sig_s <= sync1;
      sig_d <= sig_s;
    end
  end

  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) state <= S_WAIT;
    else       state <= state_nx;
  end

  // A rise wins over the timeout when both land in the same cycle.
  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    tick     = 1'b0;
    close    = 1'b0;
    expire   = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (rise) begin
          arm      = 1'b1;
          state_nx = S_MEAS;
        end
      end
      S_MEAS: begin
        if (rise) begin
          close = 1'b1;
        end else if (per_acc == LIMIT) begin
          expire   = 1'b1;
          state_nx = S_WAIT;
        end else begin
          tick = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      per_acc      <= '0;
      hi_acc       <= '0;
      per_sum      <= '0;
      hi_sum       <= '0;
      avg_idx      <= '0;
      period_cnt   <= '0;
      high_cnt     <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (arm) begin
        per_acc <= CNT_W'(1);
        hi_acc  <= CNT_W'(1);
        per_sum <= '0;
        hi_sum  <= '0;
        avg_idx <= '0;
      end
      if (tick) begin
        per_acc <= per_acc + CNT_W'(1);
        hi_acc  <= hi_acc + CNT_W'(sig_s);
      end
      if (close) begin
        per_acc <= CNT_W'(1);
        hi_acc  <= CNT_W'(1);
        if (fire) begin
          avg_idx      <= '0;
          per_sum      <= '0;
          hi_sum       <= '0;
          period_cnt   <= CNT_W'(per_tot >> AVG_LOG2);
          high_cnt     <= CNT_W'(hi_tot >> AVG_LOG2);
          period_valid <= 1'b1;
          no_signal    <= 1'b0;
        end else begin
          avg_idx <= avg_idx + IW'(1);
          per_sum <= per_tot;
          hi_sum  <= hi_tot;
        end
      end
      if (expire) begin
        per_acc   <= '0;
        hi_acc    <= '0;
        per_sum   <= '0;
        hi_sum    <= '0;
        avg_idx   <= '0;
        timeout   <= 1'b1;
        no_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: one unaveraged and one 4x-averaged
// instance, both with a 2000-cycle dead-input limit.
module tb_period_meter;

  logic        clk_100m = 1'b0;
  logic        rstn_a = 1'b0, rstn_b = 1'b0;
  logic        sig_a = 1'b0, sig_b = 1'b0;
  logic [31:0] pa, ha, pb, hb;
  logic        va, ta, nsa, vb, tb, nsb;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_a = 0;
  int last_b = 0;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    int gap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  period_meter #(.CNT_W(32), .AVG_LOG2(0), .TIMEOUT_CYC(2000)) dut_a (
    .clk_100m(clk_100m), .rstn(rstn_a), .sig_in(sig_a),
    .period_cnt(pa), .high_cnt(ha), .period_valid(va),
    .timeout(ta), .no_signal(nsa)
  );

  period_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT_CYC(2000)) dut_b (
    .clk_100m(clk_100m), .rstn(rstn_b), .sig_in(sig_b),
    .period_cnt(pb), .high_cnt(hb), .period_valid(vb),
    .timeout(tb), .no_signal(nsb)
  );

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_ev(input string tag, input exp_t e,
                          input logic is_to, input logic [31:0] p,
                          input logic [31:0] h, input int gap);
    chk({tag, "_kind"}, is_to, e.is_to);
    if (!e.is_to) begin
      chk({tag, "_period"}, p, e.per);
      chk({tag, "_high"}, h, e.hi);
    end
    if (e.gap > 0) chk({tag, "_gap"}, gap, e.gap);
  endtask

  // Monitors: every pulse consumes one expected event.
  always @(negedge clk_100m) begin
    if (va || ta) begin
      chk("a_excl", va && ta, 0);
      if (qa.size() == 0) chk("a_unexpected", 1, 0);
      else check_ev("a", qa.pop_front(), ta, pa, ha, cyc - last_a);
      last_a = cyc;
    end
  end

  always @(negedge clk_100m) begin
    if (vb || tb) begin
      chk("b_excl", vb && tb, 0);
      if (qb.size() == 0) chk("b_unexpected", 1, 0);
      else check_ev("b", qb.pop_front(), tb, pb, hb, cyc - last_b);
      last_b = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic wave_a(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      sig_a = (i < h);
      @(posedge clk_100m);
      #1;
    end
  endtask

  task automatic wave_b(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      sig_b = (i < h);
      @(posedge clk_100m);
      #1;
    end
  endtask

  initial begin
    cycles(3);
    chk("rst_a_nosig", nsa, 1);
    chk("rst_a_period", pa, 0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    cycles(100);
    chk("idle_a_period", pa, 0);
    chk("idle_a_high", ha, 0);
    chk("idle_a_nosig", nsa, 1);
    chk("idle_b_nosig", nsb, 1);

    // 778/389 for 4 periods, then dead input
    qa.push_back(exp_t'{0, 778, 389, 0});
    qa.push_back(exp_t'{0, 778, 389, 778});
    qa.push_back(exp_t'{0, 778, 389, 778});
    qa.push_back(exp_t'{1, 0, 0, 2000});
    repeat (4) wave_a(778, 389);
    chk("a_nosig_live", nsa, 0);
    cycles(2010);
    chk("a_nosig_dead", nsa, 1);
    chk("a_hold_period", pa, 778);
    chk("a_hold_high", ha, 389);

    // Period exactly at the timeout limit is still valid
    qa.push_back(exp_t'{0, 2000, 1000, 0});
    qa.push_back(exp_t'{0, 2000, 1000, 2000});
    qa.push_back(exp_t'{1, 0, 0, 2000});
    repeat (3) wave_a(2000, 1000);
    chk("a_limit_nosig", nsa, 0);
    cycles(2010);
    chk("a_limit_dead", nsa, 1);

    // 4-period average: 4007 >> 2 = 1001, 2000 >> 2 = 500
    qb.push_back(exp_t'{0, 1001, 500, 0});
    qb.push_back(exp_t'{1, 0, 0, 2000});
    wave_b(1000, 500);
    wave_b(1001, 500);
    wave_b(1002, 500);
    chk("b_no_early", nsb, 1);
    wave_b(1004, 500);
    wave_b(1, 1);
    sig_b = 1'b0;
    cycles(5);
    chk("b_avg_period", pb, 1001);
    chk("b_avg_nosig", nsb, 0);
    cycles(2010);

    // Reset in the middle of an averaging block
    wave_b(500, 250);
    wave_b(500, 250);
    sig_b = 1'b1;
    cycles(100);
    rstn_b = 1'b0;
    #1;
    chk("b_rst_period", pb, 0);
    chk("b_rst_high", hb, 0);
    chk("b_rst_nosig", nsb, 1);
    sig_b = 1'b0;
    cycles(3);
    rstn_b = 1'b1;
    cycles(2);
    qb.push_back(exp_t'{0, 500, 250, 0});
    qb.push_back(exp_t'{1, 0, 0, 2000});
    repeat (3) wave_b(500, 250);
    chk("b_rst_no_early", nsb, 1);
    wave_b(500, 250);
    wave_b(1, 1);
    sig_b = 1'b0;
    cycles(2010);
    chk("b_rst_result", pb, 500);

    cycles(5);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow external square wave, such as the excitation or zero-crossing comparator output, in clk_100m cycles. It optionally averages the measurement over 2^AVG_LOG2 periods. The block sits beside the sample-clock divider in the impedance front end. Downstream frequency and phase logic read its results through a one-cycle valid strobe.

## Interface
- CNT_W, 32: width of the period and high-time counters and outputs.
- AVG_LOG2, 0: the block averages 2^AVG_LOG2 consecutive periods per result. Range 0..4.
- TIMEOUT_CYC, 10_000_000: number of cycles without a rising edge before the input is declared dead. The default is 100 ms at 100 MHz, giving a 10 Hz floor. Must be less than 2^CNT_W.

Ports:
- clk_100m  input  1  system clock, 100 MHz.
- rstn  input  1  asynchronous, active-low reset.
- sig_in  input  1  asynchronous square wave to be measured.
- period_cnt  output  CNT_W  averaged period, in clk_100m cycles.
- high_cnt  output  CNT_W  averaged high time, in clk_100m cycles.
- period_valid  output  1  one-cycle pulse, asserted when period_cnt and high_cnt update.
- timeout  output  1  one-cycle pulse, asserted when the timeout fires.
- no_signal  output  1  level. High from reset or a timeout until the next period_valid.

## Operation
- Synchronizer: two flops, sync1 then sig_s, followed by one delay flop sig_d.
  - rise = sig_s & ~sig_d.
- State machine has two states, S_WAIT and S_MEAS.
  - S_WAIT: accumulators are idle. On rise: per_acc<=1, hi_acc<=1, sums<=0, avg_idx<=0, go to S_MEAS.
  - S_MEAS, no rise, and per_acc != TIMEOUT_CYC: per_acc<=per_acc+1, hi_acc<=hi_acc+sig_s.
  - S_MEAS on rise: one period completes.
    - per_sum<=per_sum+per_acc and hi_sum<=hi_sum+hi_acc.
    - per_acc<=1, hi_acc<=1, avg_idx<=avg_idx+1.
  - S_MEAS, no rise, and per_acc == TIMEOUT_CYC:
    - timeout<=1 for one cycle and no_signal<=1.
    - Discard the partial sums; period_cnt and high_cnt hold their values.
    - Go to S_WAIT.
- Result: on the rise that completes block element 2^AVG_LOG2-1 (avg_idx wraps to 0):
  - period_cnt<=(per_sum+per_acc)>>AVG_LOG2, truncating toward zero.
  - high_cnt<=(hi_sum+hi_acc)>>AVG_LOG2, truncating toward zero.
  - Sums clear to 0; period_valid<=1; no_signal<=0.
- Width rules:
  - Sums are CNT_W+AVG_LOG2 bits wide, so they cannot overflow.
  - per_acc never exceeds TIMEOUT_CYC.
  - hi_acc <= per_acc always.
- Period semantics: rising edges of sig_s that are P cycles apart yield per_acc == P at the second edge.
- High-time semantics: H = the number of cycles sig_s is high, counted from and including the rise cycle.
- Priority: rise beats timeout in the same cycle. A rise with per_acc == TIMEOUT_CYC is a valid period.
- The first rise after reset or a timeout only arms the measurement. It never produces a result.
- Constant-high or constant-low input produces no rise, so only the timeout behaviour applies.

## Timing
- Reset values:
  - period_cnt=0, high_cnt=0, period_valid=0, timeout=0, no_signal=1.
  - State S_WAIT; all accumulators 0.
  - Synchronizer flops 0.
- Reset mid-measurement: everything returns to the reset values immediately (asynchronously). Partial sums are lost.
- Latency: sig_in first sampled high at edge E0 gives sig_s=1 after E1. The rise is evaluated in the cycle after E1. Results and the period_valid pulse are registered at E2.
- period_valid and timeout are each high for exactly one cycle. They are never asserted in the same cycle.
- Results are stable between period_valid pulses.
- Minimum measurable period is 2 cycles, since sig_s must go low for at least one cycle.
- Maximum measurable period is TIMEOUT_CYC.

## Test plan
- Reset, then sig_in low for 100 cycles -> all outputs 0, no_signal=1, no pulses.
- AVG_LOG2=0; sig_in with period 778 and high 389 cycles, synchronous to clk_100m, for 4 periods -> period_valid pulses 3 times, 778 cycles apart. Each pulse reports period_cnt=778, high_cnt=389. no_signal falls with the first pulse.
- AVG_LOG2=2; periods 1000, 1001, 1002, 1004 with high 500 -> one period_valid, period_cnt=1001 (4007>>2), high_cnt=500.
- TIMEOUT_CYC=2000; two rises 778 cycles apart, then sig_in held low -> one valid result, period_cnt=778. A timeout pulse follows 2000 cycles after the last rise's per_acc reset. no_signal=1; period_cnt still reads 778.
- TIMEOUT_CYC=2000; rises exactly 2000 cycles apart -> period_valid with period_cnt=2000, and no timeout pulse.
- Assert rstn low mid-period with AVG_LOG2=2 after 2 of 4 periods, then release and apply a 500-cycle period -> the first result appears only after 4 full periods after the arming rise, period_cnt=500.
